// File: rtl/gray_counter_src.sv
// gray_counter_src: registered Gray-code counter behind a single-entry
// valid/ready output stage. Supports up/down stepping, binary parallel load
// (load wins over en) and a one-cycle wrap pulse.
// Optional macro GRAY_CNT_CHECK_EN adds a sticky checker that raises err
// whenever a step changes other than exactly one bit of the code; without it
// err is tied to 0 and the port list is unchanged.
module gray_counter_src #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    output logic         gray_valid,
    input  logic         gray_ready,
    output logic [N-1:0] gray,
    output logic         wrap,
    output logic         err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         acc_c;

    // Output stage can take a new value when empty or when the consumer drains it
    assign acc_c = (state_q == EMPTY) || gray_ready;

    // Next-state, next-count and wrap decode
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wrap_d  = 1'b0;
        if (load) begin
            bin_d   = load_bin;
            state_d = FULL;
        end else if (en && acc_c) begin
            if (up) begin
                bin_d  = bin_q + N'(1);
                wrap_d = (bin_q == {N{1'b1}});
            end else begin
                bin_d  = bin_q - N'(1);
                wrap_d = (bin_q == {N{1'b0}});
            end
            state_d = FULL;
        end else if ((state_q == FULL) && gray_ready) begin
            state_d = EMPTY;
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State, count, code and wrap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            bin_q   <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gray_valid = (state_q == FULL);
    assign gray       = gray_q;
    assign wrap       = wrap_q;

`ifdef GRAY_CNT_CHECK_EN
    logic step_c;
    logic err_q;

    assign step_c = en && !load && acc_c;

    // Sticky flag: a step must flip exactly one code bit; loads are exempt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (step_c && ($countones(gray_q ^ gray_d) != 1)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/gray_counter_src.md
# gray_counter_src

Registered Gray-code counter that produces the Gray-coded values consumed by the `gray_to_binary` converter. Output is a single-entry valid/ready stage, so the code only advances when the consumer has taken the previous value. Supports up/down counting, binary parallel load and a wrap pulse. An optional checker flags any step that is not a single-bit Gray transition.

## Interface
- `N`, default 4: counter and code width in bits; N ≥ 2.
- `clk  input  1`: rising-edge clock.
- `rst  input  1`: reset, asynchronous and active-high.
- `en  input  1`: step request; counter advances by one when accepted.
- `up  input  1`: direction; 1 = increment, 0 = decrement. Sampled only on an accepted step.
- `load  input  1`: parallel load request; has priority over `en`.
- `load_bin  input  N`: binary value to load.
- `gray_valid  output  1`: `gray` holds a value not yet accepted.
- `gray_ready  input  1`: consumer accepts `gray` this cycle when `gray_valid=1`.
- `gray  output  N`: registered Gray code of the internal binary count.
- `wrap  output  1`: one-cycle pulse accompanying a step that crossed the 2^N−1↔0 boundary.
- `err  output  1`: sticky Gray-property violation flag; tied 0 when the checker is compiled out.

## Operation
- Internal state:
  - `bin_q[N-1:0]`: binary count.
  - Two-state output FSM: EMPTY (`gray_valid=0`) and FULL (`gray_valid=1`).
- `gray` is always registered as `bin_q ^ (bin_q >> 1)`, updated in the same edge as `bin_q`.
- Accept condition: `acc = !gray_valid || gray_ready`.
- Step: `en && !load && acc`.
  - `up=1`: `bin_q <= bin_q + 1` mod 2^N.
  - `up=0`: `bin_q <= bin_q − 1` mod 2^N.
  - FSM goes to FULL.
- Load: `load`, regardless of `acc`.
  - `bin_q <= load_bin`; FSM goes to FULL.
  - Any unaccepted value is discarded.
  - `wrap` is 0.
- No step, no load:
  - FULL with `gray_ready=1` goes to EMPTY.
  - Otherwise the FSM holds; `bin_q` and `gray` are unchanged.
- FSM transitions:
  - EMPTY→FULL on a step or load.
  - FULL→FULL on a step with ready, on a load, or while not ready.
  - FULL→EMPTY on ready with no step or load.
- `wrap` is 1 for exactly the cycle after a step from 2^N−1 to 0 (up) or from 0 to 2^N−1 (down); otherwise 0.
- `en` while FULL and `!gray_ready` is ignored (not queued); the counter stalls.
- All arithmetic is N bits, unsigned, modulo 2^N; no saturation.

## Timing
- Reset values: `bin_q=0`, `gray=0`, `gray_valid=0`, `wrap=0`, `err=0`, FSM in EMPTY.
- Reset asserted mid-operation clears everything immediately, including a pending FULL value.
- Latency: a step or load accepted at edge k gives the new `gray`, `gray_valid=1` and `wrap` after edge k.
- Throughput: one code per cycle with `en=1` and `gray_ready=1` held continuously.
- `gray` and `gray_valid` are stable while `gray_valid=1` and `gray_ready=0`, unless `load` is asserted.
- Simultaneous `load` and `en`: load wins and no step occurs.
- Simultaneous `gray_ready` and a step: the current value is consumed and the next value is presented after the edge, with no bubble.

## Configuration
- Macro: `GRAY_CNT_CHECK_EN`.
- Defined:
  - On every step, compute the popcount of (old `gray` XOR new Gray value).
  - If it is not exactly 1, set `err` at the same edge. `err` stays 1 until reset.
  - Loads are excluded from the check.
- Undefined: no checker logic is present; `err` is constant 0. Port list is identical in both builds.

## Test plan
- Reset, then `en=1, up=1, gray_ready=1` for 16 cycles (N=4):
  - `gray` = 0001, 0011, 0010, 0110, … , 1000, then 0000.
  - `wrap=1` only with 0000.
  - `gray_valid=1` throughout.
- `load=1, load_bin=0000`, then `en=1, up=0, ready=1`:
  - `gray` = 0000, then 1000 (bin 1111) with `wrap=1`, then 1001 (bin 1110).
- Backpressure:
  - Step to bin 5 (gray 0111), then `gray_ready=0` for 4 cycles with `en=1`.
  - `gray` holds 0111 and `gray_valid` holds 1.
  - On `ready=1`, the next value is 0101 (bin 6).
- `load=1, en=1` together with `load_bin=1010` → `gray=1111` (not a step). Then `en=0, ready=1` → `gray_valid` falls to 0 after one cycle.
- Assert `rst` while FULL at bin 9 (gray 1101) → `gray=0000`, `gray_valid=0`, `wrap=0` immediately, without waiting for a clock edge.
- With `GRAY_CNT_CHECK_EN`: run 64 random steps and loads → `err` stays 0. Then force the internal next code to skip one value → `err=1` and stays 1 until reset.
